// File: rtl/sdram_device_model.sv
// sdram_device_model: x16 SDRAM responder with init tracking, protocol/timing checks and a reduced array
module sdram_device_model #(
  parameter int ROW_W    = 4,
  parameter int COL_W    = 6,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2,
  parameter int T_RAS    = 3,
  parameter int T_RFC    = 4,
  parameter int T_MRD    = 2,
  parameter int REFI_MAX = 390
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_bank,
  input  logic [12:0] sd_addr,
  input  logic [15:0] sd_data_in,
  input  logic        sd_drive_data,
  output logic [15:0] sd_data_out,
  output logic        sd_data_oe,
  output logic        ready,
  output logic        err_protocol,
  output logic        err_timing,
  output logic        err_refresh
);
  localparam int AW = 2 + ROW_W + COL_W;
  localparam logic [7:0] RCD = 8'(T_RCD);
  localparam logic [7:0] RP = 8'(T_RP);
  localparam logic [7:0] RAS = 8'(T_RAS);
  localparam logic [7:0] RFC = 8'(T_RFC);
  localparam logic [7:0] MRD = 8'(T_MRD);
  localparam logic [15:0] REFI = 16'(REFI_MAX);
  typedef enum logic [2:0] {POWERUP, PRE_DONE, REF1, REF2, READY} init_t;
  init_t state, state_nx;
  logic [15:0] mem [2**AW];
  logic [2:0] cmd, cl;
  logic c_act, c_rd, c_wr, c_pre, c_ref, c_mrs, c_any;
  logic [3:0] open_b, pre_mask;
  logic [ROW_W-1:0] row_b [4];
  logic [7:0] t_act [4];
  logic [7:0] t_pre [4];
  logic [7:0] t_ref, t_mrs;
  logic [15:0] refi;
  logic bank_open, mrs_ok, act_go, rd_go, wr_go, ras_v, rp_v, e_proto, e_timing;
  logic [AW-1:0] idx;
  logic s1_v, s2_v;
  logic [15:0] s1_d, s2_d;
  logic unused;

  function automatic logic [7:0] inc8(input logic [7:0] v);
    return v + {7'd0, v != 8'hff};
  endfunction

  assign unused = ^sd_addr;
  assign cmd = sd_cs ? 3'b111 : {sd_ras, sd_cas, sd_we};
  assign c_act = cmd == 3'b011;
  assign c_rd = cmd == 3'b101;
  assign c_wr = cmd == 3'b100;
  assign c_pre = cmd == 3'b010;
  assign c_ref = cmd == 3'b001;
  assign c_mrs = cmd == 3'b000;
  assign c_any = cmd[2:1] != 2'b11;
  assign bank_open = open_b[sd_bank];
  assign pre_mask = sd_addr[10] ? 4'hf : 4'b0001 << sd_bank;
  assign mrs_ok = c_mrs && sd_addr[6:5] == 2'b01 && sd_addr[2:0] == 3'd0;
  assign act_go = c_act && ready && !bank_open;
  assign rd_go = c_rd && ready && bank_open;
  assign wr_go = c_wr && ready && bank_open && sd_drive_data;
  assign idx = {sd_bank, row_b[sd_bank], sd_addr[COL_W-1:0]};

  always_comb begin
    ras_v = 1'b0;
    rp_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ras_v = ras_v | (pre_mask[i] && open_b[i] && t_act[i] < RAS);
      rp_v = rp_v | (t_pre[i] < RP);
    end
  end

  assign e_proto = ((c_act || c_rd || c_wr) && !ready) || (c_act && ready && bank_open) ||
                   ((c_rd || c_wr) && ready && !bank_open) || (c_wr && !sd_drive_data) ||
                   (c_ref && |open_b) || (c_mrs && !mrs_ok) || (sd_data_oe && sd_drive_data);
  assign e_timing = ((c_rd || c_wr) && t_act[sd_bank] < RCD) || (c_act && t_pre[sd_bank] < RP) ||
                    (c_pre && ras_v) || (c_ref && rp_v) || (c_any && (t_ref < RFC || t_mrs < MRD));

  always_ff @(posedge clk) state <= reset ? POWERUP : state_nx;

  always_comb
    state_nx = (state == POWERUP && c_pre && sd_addr[10]) ? PRE_DONE :
               (state == PRE_DONE && c_ref) ? REF1 :
               (state == REF1 && c_ref) ? REF2 :
               (state == REF2 && mrs_ok) ? READY : state;

  always_comb ready = state == READY;

  always_ff @(posedge clk) begin
    if (reset) begin
      open_b <= '0;
      cl <= 3'd2;
      t_ref <= '1;
      t_mrs <= '1;
      refi <= '0;
      err_protocol <= 1'b0;
      err_timing <= 1'b0;
      err_refresh <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        t_act[i] <= '1;
        t_pre[i] <= '1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        t_act[i] <= (act_go && sd_bank == 2'(i)) ? 8'd1 : inc8(t_act[i]);
        t_pre[i] <= (c_pre && pre_mask[i]) ? 8'd1 : inc8(t_pre[i]);
        if (act_go && sd_bank == 2'(i)) row_b[i] <= sd_addr[ROW_W-1:0];
      end
      open_b <= (c_pre ? open_b & ~pre_mask : open_b) | (act_go ? 4'b0001 << sd_bank : 4'd0);
      t_ref <= c_ref ? 8'd1 : inc8(t_ref);
      t_mrs <= c_mrs ? 8'd1 : inc8(t_mrs);
      if (mrs_ok) cl <= sd_addr[6:4];
      refi <= (!ready || c_ref) ? 16'd0 : refi + {15'd0, refi != 16'hffff};
      err_protocol <= err_protocol | e_proto;
      err_timing <= err_timing | e_timing;
      err_refresh <= err_refresh | (ready && refi >= REFI);
    end
  end

  // CL=3 reads enter one stage earlier so both latencies share the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_d <= '0;
      s2_d <= '0;
      sd_data_oe <= 1'b0;
      sd_data_out <= '0;
    end else begin
      s2_v <= rd_go && cl == 3'd3;
      s2_d <= mem[idx];
      s1_v <= (rd_go && cl != 3'd3) || s2_v;
      s1_d <= (rd_go && cl != 3'd3) ? mem[idx] : s2_d;
      sd_data_oe <= s1_v;
      sd_data_out <= s1_d;
    end
  end

  always_ff @(posedge clk)
    if (wr_go && !reset) begin
      if (!sd_addr[11]) mem[idx][7:0] <= sd_data_in[7:0];
      if (!sd_addr[12]) mem[idx][15:8] <= sd_data_in[15:8];
    end
endmodule

// File: tb/tb_sdram_device_model.sv
// tb_sdram_device_model: randomized scoreboard bench for the SDRAM responder
module tb_sdram_device_model;
  localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010, REF = 3'b001, MRS = 3'b000;
  logic clk = 0, reset = 1, sd_cs = 1, sd_ras = 1, sd_cas = 1, sd_we = 1, sd_drive_data = 0;
  logic [1:0] sd_bank = 0;
  logic [12:0] sd_addr = 0;
  logic [15:0] sd_data_in = 0;
  logic [15:0] sd_data_out;
  logic sd_data_oe, ready, err_protocol, err_timing, err_refresh;
  typedef struct {logic [15:0] d; int due;} exp_t;
  exp_t exp_q[$];
  logic [15:0] mem_m [int];
  logic [3:0] open_m = 0;
  logic [12:0] row_m [4];
  int cl_m = 2, cyc = 0, last_due = -1, last_ref = 0, oe_cnt = 0, nchk = 0, nfail = 0, snap;
  bit rdy_m = 0;

  sdram_device_model dut (
    .clk(clk), .reset(reset), .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
    .sd_bank(sd_bank), .sd_addr(sd_addr), .sd_data_in(sd_data_in), .sd_drive_data(sd_drive_data),
    .sd_data_out(sd_data_out), .sd_data_oe(sd_data_oe), .ready(ready),
    .err_protocol(err_protocol), .err_timing(err_timing), .err_refresh(err_refresh)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", n, act, exp, cyc);
    end
  endfunction

  always @(negedge clk)
    if (!reset) begin
      if (sd_data_oe) begin
        oe_cnt++;
        if (exp_q.size() == 0) chk("oe_without_read", {31'd0, sd_data_oe}, 0);
        else begin
          chk("rd_data", {16'd0, sd_data_out}, {16'd0, exp_q[0].d});
          chk("rd_cycle", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("rd_missing", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a, input logic [15:0] d, input int gap);
    int k;
    logic [15:0] old;
    k = int'({b, row_m[b][3:0], a[5:0]});
    old = mem_m.exists(k) ? mem_m[k] : 16'h0;
    if (c == RD && rdy_m && open_m[b]) begin
      exp_q.push_back(exp_t'{old, cyc + cl_m});
      last_due = cyc + cl_m;
    end
    if (c == WR && rdy_m && open_m[b]) mem_m[k] = {a[12] ? old[15:8] : d[15:8], a[11] ? old[7:0] : d[7:0]};
    if (c == ACT && rdy_m && !open_m[b]) begin
      open_m[b] = 1'b1;
      row_m[b] = a;
    end
    if (c == PRE) open_m = a[10] ? 4'h0 : open_m & ~(4'b0001 << b);
    if (c == MRS) cl_m = int'(a[6:4]);
    if (c == REF) last_ref = cyc;
    sd_cs = 0;
    {sd_ras, sd_cas, sd_we} = c;
    sd_bank = b;
    sd_addr = a;
    sd_data_in = d;
    sd_drive_data = c == WR;
    tick(1);
    sd_cs = 1;
    {sd_ras, sd_cas, sd_we} = 3'b111;
    sd_drive_data = 0;
    tick(gap - 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) tick(1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic init(input logic [12:0] mode);
    reset = 1;
    tick(3);
    reset = 0;
    exp_q.delete();
    open_m = 0;
    rdy_m = 0;
    cl_m = 2;
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_flags", {29'd0, err_protocol, err_timing, err_refresh}, 0);
    chk("rst_oe", {31'd0, sd_data_oe}, 0);
    cmd(PRE, 0, 13'h400, 0, 4);
    cmd(REF, 0, 0, 0, 4);
    cmd(REF, 0, 0, 0, 4);
    chk("ready_before_mrs", {31'd0, ready}, 0);
    cmd(MRS, 0, mode, 0, 1);
    chk("ready_after_mrs", {31'd0, ready}, 1);
    chk("init_flags", {29'd0, err_protocol, err_timing, err_refresh}, 0);
    rdy_m = 1;
    tick(2);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic [1:0] b;
      logic [12:0] a;
      int op, k;
      b = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (cyc - last_ref > 200) begin
        cmd(PRE, 0, 13'h400, 0, 2);
        cmd(REF, 0, 0, 0, 4);
      end else if (!open_m[b]) cmd(ACT, b, {9'($urandom), 4'($urandom_range(0, 3))}, 0, 3);
      else if (op == 0) cmd(PRE, b, 13'h0, 0, 2);
      else begin
        a = {3'b000, 4'($urandom), 6'($urandom_range(0, 7))};
        k = int'({b, row_m[b][3:0], a[5:0]});
        if (op >= 6 && mem_m.exists(k)) cmd(RD, b, a, 0, $urandom_range(1, 2));
        else begin
          if (mem_m.exists(k)) a[12:11] = 2'($urandom);
          while (cyc <= last_due) tick(1);
          cmd(WR, b, a, 16'($urandom), $urandom_range(1, 2));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    init(13'h020);
    cmd(ACT, 1, 13'd5, 0, 2);
    cmd(WR, 1, 13'd3, 16'hBEEF, 2);
    cmd(RD, 1, 13'd3, 0, 1);
    cmd(WR, 1, 13'h1003, 16'h1234, 1);
    cmd(RD, 1, 13'd3, 0, 1);
    cmd(RD, 1, 13'd3, 0, 4);
    cmd(WR, 1, 13'h0803, 16'h5678, 2);
    cmd(RD, 1, 13'd3, 0, 4);
    drain();
    chk("data_flags", {29'd0, err_protocol, err_timing, err_refresh}, 0);
    rand_phase(150);
    drain();
    cmd(MRS, 0, 13'h030, 0, 2);
    rand_phase(150);
    drain();
    chk("rand_flags", {29'd0, err_protocol, err_timing, err_refresh}, 0);
    chk("rand_ready", {31'd0, ready}, 1);
    cmd(PRE, 0, 13'h400, 0, 2);
    cmd(ACT, 1, 13'd5, 0, 1);
    cmd(RD, 1, 13'd3, 0, 5);
    drain();
    chk("trcd_timing", {31'd0, err_timing}, 1);
    chk("trcd_protocol", {31'd0, err_protocol}, 0);
    init(13'h020);
    snap = oe_cnt;
    cmd(RD, 2, 13'd3, 0, 5);
    chk("closed_rd_protocol", {31'd0, err_protocol}, 1);
    chk("closed_rd_timing", {31'd0, err_timing}, 0);
    chk("closed_rd_oe", oe_cnt, snap);
    init(13'h020);
    snap = oe_cnt;
    cmd(ACT, 0, 13'd1, 0, 4);
    cmd(REF, 0, 0, 0, 4);
    chk("ref_open_protocol", {31'd0, err_protocol}, 1);
    chk("ref_open_timing", {31'd0, err_timing}, 0);
    chk("ref_open_oe", oe_cnt, snap);
    init(13'h020);
    snap = oe_cnt;
    cmd(ACT, 1, 13'd5, 0, 2);
    cmd(RD, 1, 13'd3, 0, 1);
    reset = 1;
    tick(1);
    reset = 0;
    exp_q.delete();
    open_m = 0;
    rdy_m = 0;
    chk("rst_cancel_oe", {31'd0, sd_data_oe}, 0);
    tick(4);
    chk("rst_cancel_cnt", oe_cnt, snap);
    init(13'h020);
    tick(290);
    chk("refi_early", {31'd0, err_refresh}, 0);
    tick(110);
    chk("refi_late", {31'd0, err_refresh}, 1);
    reset = 1;
    tick(2);
    reset = 0;
    chk("final_flags", {29'd0, err_protocol, err_timing, err_refresh}, 0);
    chk("final_ready", {31'd0, ready}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
